// File: rtl/mips_load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed, synchronous-read data memory.
// Sub-word stores use read-modify-write. Loads return sign- or zero-extended data.
module mips_load_store_unit #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a posedge where req_valid && req_ready;
   // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_CAP = 2'd2, S_WR = 2'd3} state_e;

   state_e      state_q, state_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   logic        req_err;
   logic [1:0]  byte_sel;
   logic        half_sel;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Lane numbers counted from bit 0; big-endian puts offset 0 in the top lane.
   assign byte_sel = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
   assign half_sel = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
   assign rd_byte  = mem_rdata[{byte_sel, 3'b000} +: 8];
   assign rd_half  = mem_rdata[{half_sel, 4'b0000} +: 16];

   always_comb begin
      load_ext = mem_rdata;
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
         2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      merged = mem_rdata;
      if (size_q == 2'b00) begin
         merged[{byte_sel, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{half_sel, 4'b0000} +: 16] = wdata_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      mem_wdata_d  = mem_wdata_q;
      wr_d         = wr_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata[15:0];
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else if (req_write && req_size == 2'b10) begin
                  mem_wdata_d = req_wdata;
                  state_d     = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: state_d = S_CAP;
         S_CAP: begin
            if (wr_q) begin
               mem_wdata_d = merged;
               state_d     = S_WR;
            end else begin
               resp_rdata_d = load_ext;
               resp_valid_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         S_WR: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_wdata_q  <= 32'h0;
         wr_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 16'h0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_wdata_q  <= mem_wdata_d;
         wr_q         <= wr_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   // Strobes are gated by rst_n so a reset edge never commits a memory access.
   assign mem_read   = rst_n && (state_q == S_RD);
   assign mem_write  = rst_n && (state_q == S_WR);
   assign mem_addr   = {2'b00, addr_q[31:2]};
   assign mem_wdata  = mem_wdata_q;
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Bench for mips_load_store_unit: directed vector table, reset corner cases,
// then random requests checked against a byte-level memory model.
module tb_mips_load_store_unit;

   localparam bit BE = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];

   typedef struct {
      bit          w;
      logic [1:0]  size;
      bit          uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t tbl[$];

   mips_load_store_unit #(.BIG_ENDIAN(BE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state)
   );

   // ---- clock ----
   always #5 clk = ~clk;

   // ---- data memory: 256 words, one-cycle registered read ----
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
   end
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---- reference model: memory viewed as bytes at increasing addresses ----
   function automatic bit is_err(logic [1:0] size, logic [31:0] addr);
      int n = 1 << size;
      return (size == 2'b11) || ((addr % n) != 0);
   endfunction

   function automatic logic [31:0] ref_load(logic [31:0] word, int off, logic [1:0] size, bit uns);
      int n = 1 << size;
      logic [7:0] b[4];
      logic [31:0] v = 0;
      for (int i = 0; i < 4; i++) b[i] = BE ? word[31-8*i -: 8] : word[8*i +: 8];
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(BE ? b[off+i] : b[off+n-1-i]);
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic logic [31:0] ref_store(logic [31:0] word, int off, logic [1:0] size, logic [31:0] data);
      int n = 1 << size;
      logic [7:0] b[4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) b[i] = BE ? word[31-8*i -: 8] : word[8*i +: 8];
      for (int i = 0; i < n; i++) b[off+i] = BE ? data[8*(n-1-i) +: 8] : data[8*i +: 8];
      r = 0;
      for (int i = 0; i < 4; i++) begin
         if (BE) r[31-8*i -: 8] = b[i];
         else    r[8*i +: 8]    = b[i];
      end
      return r;
   endfunction

   // ---- driver: one request, waits for its response, checks protocol ----
   task automatic run_req(input bit w, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err);
      int idx = int'(addr[9:2]);
      logic [31:0] exp_word;
      int exp_lat, got_lat, reads, writes, both;
      logic [31:0] got_rdata;
      logic got_err;
      exp_word = (size == 2'b10) ? wdata : ref_store(ref_mem[idx], int'(addr[1:0]), size, wdata);
      exp_lat  = exp_err ? 0 : (w && size == 2'b10) ? 1 : !w ? 2 : 3;
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      got_lat = -1; reads = 0; writes = 0; both = 0; got_rdata = 0; got_err = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mem_read && mem_write) both++;
         if (mem_read) begin
            reads++;
            check("rd_addr", mem_addr, {2'b00, addr[31:2]});
         end
         if (mem_write) begin
            writes++;
            check("wr_addr", mem_addr, {2'b00, addr[31:2]});
            check("wr_data", mem_wdata, exp_word);
         end
         if (resp_valid) begin
            got_lat = k; got_rdata = resp_rdata; got_err = resp_err;
            break;
         end
         check("busy_not_ready", 32'(req_ready), 32'd0);
         // junk on the request bus while busy must be ignored
         req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
      end
      req_valid = 1'b0;
      if (got_lat < 0) begin
         n_tests++; n_fail++;
         $display("FAIL resp_timeout: no resp_valid within 8 cycles, addr %h", addr);
      end
      check("latency", 32'(got_lat), 32'(exp_lat));
      check("resp_rdata", got_rdata, exp_rdata);
      check("resp_err", 32'(got_err), 32'(exp_err));
      check("mem_reads", 32'(reads), 32'((!exp_err && (!w || size != 2'b10)) ? 1 : 0));
      check("mem_writes", 32'(writes), 32'((!exp_err && w) ? 1 : 0));
      check("rd_wr_overlap", 32'(both), 32'd0);
      if (w && !exp_err) ref_mem[idx] = exp_word;
   endtask

   task automatic run_model_req(input bit w, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
      bit e = is_err(size, addr);
      logic [31:0] r = (e || w) ? 32'h0 : ref_load(ref_mem[int'(addr[9:2])], int'(addr[1:0]), size, uns);
      run_req(w, size, uns, addr, wdata, r, e);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end

      // ---- reset held 2 edges with a pending request ----
      rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) begin
         @(negedge clk);
         check("rst_mem_read", 32'(mem_read), 32'd0);
         check("rst_mem_write", 32'(mem_write), 32'd0);
         check("rst_resp_valid", 32'(resp_valid), 32'd0);
      end
      req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("post_rst_resp_err", 32'(resp_err), 32'd0);
      check("post_rst_rdata", resp_rdata, 32'h0);
      check("post_rst_strobes", 32'({mem_read, mem_write}), 32'd0);

      // ---- directed vectors ----
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFF_FF80, 1'b0});
      tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000_0080, 1'b0});
      tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_7F01, 1'b0});
      tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_80FF, 1'b0});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0000_0001, 1'b0});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AB, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11AB_3344, 1'b0});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h33, 32'hFFFF_FF5A, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11AB_335A, 1'b0});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h40, 32'h1122_3344, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1122_BEEF, 1'b0});
      tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1});
      tbl.push_back('{1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h41, 32'h1234, 32'h0, 1'b1});
      foreach (tbl[i])
         run_req(tbl[i].w, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_rdata, tbl[i].exp_err);

      // ---- reset during the WR cycle of a sub-word store ----
      run_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h1122_3344, 32'h0, 1'b0);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h51; req_wdata = 32'hAB;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("sb_reached_wr", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      check("wr_gated_by_rst", 32'(mem_write), 32'd0);
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_no_resp_after", 32'(resp_valid), 32'd0);
      check("abort_mem_kept", mem[20], 32'h1122_3344);
      run_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h1122_3344, 1'b0);

      // ---- random requests against the model ----
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         run_model_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      end

      @(negedge clk);
      check("idle_resp_low", 32'(resp_valid), 32'd0);
      for (int i = 0; i < 8; i++) check("mem_vs_model", mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
